// File: rtl/spot_roi_tracker.sv
// Threshold spot finder: scans a frame from block RAM and builds clamped
// ROIs with per-ROI hit counts, published into a held result buffer.
module spot_roi_tracker #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 32,
    parameter int ADDR_W       = 14,
    parameter int COORD_W      = 10,
    parameter int NUM_ROIS_MAX = 10,
    parameter int ROI_HALF_X   = 3,
    parameter int ROI_HALF_Y   = 3,
    parameter int MEM_LATENCY  = 2
) (
    input  logic                                clk_in,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [PIX_W-1:0]                    threshold,
    input  logic [15:0]                         cam_kernels_x,
    input  logic [15:0]                         cam_lines_y,
    output logic [ADDR_W-1:0]                   mem_address,
    input  logic [PIX_W*PIX_PER_WORD-1:0]       data_in,
    output logic                                busy,
    output logic                                analysis_rdy,
    output logic [7:0]                          num_rois,
    output logic                                roi_overflow,
    output logic [NUM_ROIS_MAX*4*COORD_W-1:0]   ROIs_output,
    output logic [NUM_ROIS_MAX*8-1:0]           roi_hits
);
    localparam int PIX_IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int ENT_W     = 4 * COORD_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_PUBLISH} state_t;
    state_t state, state_nx;

    logic [15:0]          k_reg, l_reg, kern_idx, line_idx, wait_cnt;
    logic [PIX_W-1:0]     thr_reg;
    logic [COORD_W-1:0]   x_max, y_max;
    logic [PIX_IDX_W-1:0] pix_idx;
    logic [COORD_W-1:0]   wx0 [NUM_ROIS_MAX];
    logic [COORD_W-1:0]   wy0 [NUM_ROIS_MAX];
    logic [COORD_W-1:0]   wx1 [NUM_ROIS_MAX];
    logic [COORD_W-1:0]   wy1 [NUM_ROIS_MAX];
    logic [7:0]           whits [NUM_ROIS_MAX];
    logic [7:0]           wcount;
    logic                 w_ovf;

    logic [PIX_W-1:0]     pix;
    logic                 bright, last_pix, last_word;
    logic [COORD_W-1:0]   pos_x, pos_y, nx0, ny0, nx1, ny1;
    logic [COORD_W:0]     x_hi, y_hi;
    logic                 hit_any;
    logic [7:0]           hit_idx;

    assign busy      = (state != S_IDLE);
    assign pix       = data_in[PIX_W*int'(pix_idx) +: PIX_W];
    assign bright    = pix > thr_reg;
    assign last_pix  = (pix_idx == PIX_IDX_W'(PIX_PER_WORD - 1));
    assign last_word = (kern_idx == k_reg - 16'd1) && (line_idx == l_reg - 16'd1);
    assign pos_x     = COORD_W'(32'(kern_idx) * PIX_PER_WORD + 32'(pix_idx));
    assign pos_y     = COORD_W'(line_idx);

    // Clamp in one extra bit so the upper bound cannot wrap
    assign x_hi = {1'b0, pos_x} + (COORD_W+1)'(ROI_HALF_X);
    assign y_hi = {1'b0, pos_y} + (COORD_W+1)'(ROI_HALF_Y);
    assign nx0  = (pos_x >= COORD_W'(ROI_HALF_X)) ? pos_x - COORD_W'(ROI_HALF_X) : '0;
    assign ny0  = (pos_y >= COORD_W'(ROI_HALF_Y)) ? pos_y - COORD_W'(ROI_HALF_Y) : '0;
    assign nx1  = (x_hi > {1'b0, x_max}) ? x_max : x_hi[COORD_W-1:0];
    assign ny1  = (y_hi > {1'b0, y_max}) ? y_max : y_hi[COORD_W-1:0];

    // Descending walk leaves the lowest matching index
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ROIS_MAX - 1; i >= 0; i--) begin
            if (8'(i) < wcount &&
                pos_x >= wx0[i] && pos_x <= wx1[i] &&
                pos_y >= wy0[i] && pos_y <= wy1[i]) begin
                hit_any = 1'b1;
                hit_idx = 8'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (start)
                    state_nx = (cam_kernels_x == '0 || cam_lines_y == '0)
                               ? S_PUBLISH : S_WAIT;
            S_WAIT:
                if (wait_cnt == 16'(MEM_LATENCY - 1))
                    state_nx = S_SCAN;
            S_SCAN:
                if (last_pix)
                    state_nx = last_word ? S_PUBLISH : S_WAIT;
            S_PUBLISH:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            k_reg        <= '0;
            l_reg        <= '0;
            thr_reg      <= '0;
            x_max        <= '0;
            y_max        <= '0;
            kern_idx     <= '0;
            line_idx     <= '0;
            pix_idx      <= '0;
            wait_cnt     <= '0;
            wcount       <= '0;
            w_ovf        <= 1'b0;
            mem_address  <= '0;
            analysis_rdy <= 1'b0;
            num_rois     <= '0;
            roi_overflow <= 1'b0;
            ROIs_output  <= '0;
            roi_hits     <= '0;
            for (int i = 0; i < NUM_ROIS_MAX; i++) begin
                wx0[i]   <= '0;
                wy0[i]   <= '0;
                wx1[i]   <= '0;
                wy1[i]   <= '0;
                whits[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg        <= cam_kernels_x;
                        l_reg        <= cam_lines_y;
                        thr_reg      <= threshold;
                        x_max        <= COORD_W'(32'(cam_kernels_x) * PIX_PER_WORD - 1);
                        y_max        <= COORD_W'(cam_lines_y - 16'd1);
                        kern_idx     <= '0;
                        line_idx     <= '0;
                        pix_idx      <= '0;
                        wait_cnt     <= '0;
                        wcount       <= '0;
                        w_ovf        <= 1'b0;
                        mem_address  <= '0;
                        analysis_rdy <= 1'b0;
                        for (int i = 0; i < NUM_ROIS_MAX; i++) begin
                            wx0[i]   <= '0;
                            wy0[i]   <= '0;
                            wx1[i]   <= '0;
                            wy1[i]   <= '0;
                            whits[i] <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                S_SCAN: begin
                    for (int i = 0; i < NUM_ROIS_MAX; i++) begin
                        if (bright && hit_any && hit_idx == 8'(i) && whits[i] != 8'hFF)
                            whits[i] <= whits[i] + 8'd1;
                        if (bright && !hit_any && wcount == 8'(i)) begin
                            wx0[i]   <= nx0;
                            wy0[i]   <= ny0;
                            wx1[i]   <= nx1;
                            wy1[i]   <= ny1;
                            whits[i] <= 8'd1;
                        end
                    end
                    if (bright && !hit_any) begin
                        if (wcount < 8'(NUM_ROIS_MAX))
                            wcount <= wcount + 8'd1;
                        else
                            w_ovf <= 1'b1;
                    end
                    if (last_pix) begin
                        pix_idx     <= '0;
                        wait_cnt    <= '0;
                        mem_address <= mem_address + ADDR_W'(1);
                        if (kern_idx == k_reg - 16'd1) begin
                            kern_idx <= '0;
                            line_idx <= line_idx + 16'd1;
                        end else begin
                            kern_idx <= kern_idx + 16'd1;
                        end
                    end else begin
                        pix_idx <= pix_idx + PIX_IDX_W'(1);
                    end
                end
                S_PUBLISH: begin
                    num_rois     <= wcount;
                    roi_overflow <= w_ovf;
                    analysis_rdy <= 1'b1;
                    for (int i = 0; i < NUM_ROIS_MAX; i++) begin
                        if (8'(i) < wcount) begin
                            ROIs_output[ENT_W*i +: ENT_W] <= {wx0[i], wy0[i], wx1[i], wy1[i]};
                            roi_hits[8*i +: 8]            <= whits[i];
                        end else begin
                            ROIs_output[ENT_W*i +: ENT_W] <= '0;
                            roi_hits[8*i +: 8]            <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spot_roi_tracker.sv
// Directed bench for spot_roi_tracker: scoreboard of published results
// plus cycle checks of the start/busy/ready handshake.
module tb_spot_roi_tracker;
    localparam int NR = 10;
    localparam int EW = 40;

    logic              clk_in = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        threshold = '0;
    logic [15:0]       cam_kernels_x = '0;
    logic [15:0]       cam_lines_y = '0;
    logic [13:0]       mem_address;
    logic [255:0]      data_in;
    logic              busy, analysis_rdy, roi_overflow;
    logic [7:0]        num_rois;
    logic [NR*EW-1:0]  ROIs_output;
    logic [NR*8-1:0]   roi_hits;

    logic [255:0] mem [0:63];
    assign data_in = mem[mem_address[5:0]];

    always #5 clk_in = ~clk_in;

    spot_roi_tracker dut (
        .clk_in(clk_in), .reset_n(reset_n), .start(start),
        .threshold(threshold), .cam_kernels_x(cam_kernels_x),
        .cam_lines_y(cam_lines_y), .mem_address(mem_address),
        .data_in(data_in), .busy(busy), .analysis_rdy(analysis_rdy),
        .num_rois(num_rois), .roi_overflow(roi_overflow),
        .ROIs_output(ROIs_output), .roi_hits(roi_hits)
    );

    typedef struct {
        logic [7:0]       num;
        logic             ovf;
        logic [NR*EW-1:0] rois;
        logic [NR*8-1:0]  hits;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    logic mon_prev = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_clear();
        cur.num  = '0;
        cur.ovf  = 1'b0;
        cur.rois = '0;
        cur.hits = '0;
    endtask

    task automatic exp_add(input int i, input int xs, input int ys,
                           input int xe, input int ye, input int h);
        cur.rois[EW*i +: EW] = {10'(xs), 10'(ys), 10'(xe), 10'(ye)};
        cur.hits[8*i +: 8]   = 8'(h);
    endtask

    task automatic mem_clear();
        for (int w = 0; w < 64; w++) mem[w] = '0;
    endtask

    task automatic set_pix(input int w, input int p, input logic [7:0] v);
        mem[w][8*p +: 8] = v;
    endtask

    task automatic wait_rdy(input int budget);
        int n;
        n = 0;
        while (!analysis_rdy && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        tests++;
        if (!analysis_rdy) begin
            fails++;
            $display("FAIL rdy_timeout: got 0 expected 1 within %0d cycles", budget);
        end
        @(negedge clk_in);
    endtask

    task automatic run_frame(input int k, input int l, input logic [7:0] thr);
        sb.push_back(cur);
        @(negedge clk_in);
        cam_kernels_x = 16'(k);
        cam_lines_y   = 16'(l);
        threshold     = thr;
        start         = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wait_rdy(5000);
    endtask

    // Monitor: compare each published result against the oldest expectation
    always @(negedge clk_in) begin
        if (analysis_rdy && !mon_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got rdy expected none");
            end else begin
                mon_e = sb.pop_front();
                check("num_rois", 512'(num_rois), 512'(mon_e.num));
                check("roi_overflow", 512'(roi_overflow), 512'(mon_e.ovf));
                check("ROIs_output", 512'(ROIs_output), 512'(mon_e.rois));
                check("roi_hits", 512'(roi_hits), 512'(mon_e.hits));
            end
        end
        mon_prev <= analysis_rdy;
    end

    initial begin
        mem_clear();
        repeat (3) @(negedge clk_in);
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_rdy", 512'(analysis_rdy), 512'(0));
        check("rst_num", 512'(num_rois), 512'(0));
        check("rst_ovf", 512'(roi_overflow), 512'(0));
        check("rst_addr", 512'(mem_address), 512'(0));
        check("rst_rois", 512'(ROIs_output), 512'(0));
        check("rst_hits", 512'(roi_hits), 512'(0));
        reset_n = 1'b1;
        @(negedge clk_in);

        // single bright pixel
        mem_clear();
        set_pix(2, 10, 8'd200);
        exp_clear();
        cur.num = 8'd1;
        exp_add(0, 7, 0, 13, 3, 1);
        run_frame(1, 4, 8'd127);

        // second hit in same ROI; value equal to threshold is dark
        set_pix(2, 11, 8'd200);
        set_pix(0, 30, 8'd127);
        exp_clear();
        cur.num = 8'd1;
        exp_add(0, 7, 0, 13, 3, 2);
        run_frame(1, 4, 8'd127);

        // clamp at both edges
        mem_clear();
        set_pix(0, 0, 8'd200);
        set_pix(1, 31, 8'd200);
        exp_clear();
        cur.num = 8'd2;
        exp_add(0, 0, 0, 3, 1, 1);
        exp_add(1, 28, 0, 31, 1, 1);
        run_frame(1, 2, 8'd127);

        // table fills, later spots dropped, hits still counted
        mem_clear();
        for (int j = 0; j < 5; j++) begin
            set_pix(0, 7*j, 8'd200);
            set_pix(7, 7*j, 8'd200);
        end
        set_pix(8, 1, 8'd200);
        set_pix(11, 0, 8'd200);
        set_pix(11, 7, 8'd200);
        exp_clear();
        cur.num = 8'd10;
        cur.ovf = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_add(j, (7*j < 3) ? 0 : 7*j - 3, 0,
                    (7*j + 3 > 31) ? 31 : 7*j + 3, 3, 1);
            exp_add(5 + j, (7*j < 3) ? 0 : 7*j - 3, 4,
                    (7*j + 3 > 31) ? 31 : 7*j + 3, 10, (j == 0) ? 2 : 1);
        end
        run_frame(1, 12, 8'd127);

        // reset mid-scan clears everything at once
        mem_clear();
        set_pix(2, 10, 8'd200);
        @(negedge clk_in);
        cam_kernels_x = 16'd1;
        cam_lines_y   = 16'd4;
        threshold     = 8'd127;
        start         = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (20) @(negedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 512'(busy), 512'(0));
        check("arst_rdy", 512'(analysis_rdy), 512'(0));
        check("arst_num", 512'(num_rois), 512'(0));
        check("arst_ovf", 512'(roi_overflow), 512'(0));
        check("arst_rois", 512'(ROIs_output), 512'(0));
        check("arst_hits", 512'(roi_hits), 512'(0));
        @(negedge clk_in);
        reset_n = 1'b1;
        exp_clear();
        cur.num = 8'd1;
        exp_add(0, 7, 0, 13, 3, 1);
        run_frame(1, 4, 8'd127);

        // handshake timing, K=2 L=2
        mem_clear();
        set_pix(3, 5, 8'd200);
        exp_clear();
        cur.num = 8'd1;
        exp_add(0, 34, 0, 40, 1, 1);
        sb.push_back(cur);
        @(negedge clk_in);
        cam_kernels_x = 16'd2;
        cam_lines_y   = 16'd2;
        threshold     = 8'd127;
        start         = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check("t_busy_c1", 512'(busy), 512'(1));
        check("t_rdy_c1", 512'(analysis_rdy), 512'(0));
        for (int e = 0; e <= 140; e++) begin
            if (e == 33)  check("t_addr_e33", 512'(mem_address), 512'(0));
            if (e == 34)  check("t_addr_e34", 512'(mem_address), 512'(1));
            if (e == 68)  check("t_addr_e68", 512'(mem_address), 512'(2));
            if (e == 102) check("t_addr_e102", 512'(mem_address), 512'(3));
            if (e == 136) begin
                check("t_rdy_c137", 512'(analysis_rdy), 512'(0));
                check("t_busy_c137", 512'(busy), 512'(1));
            end
            if (e == 137) begin
                check("t_rdy_c138", 512'(analysis_rdy), 512'(1));
                check("t_busy_c138", 512'(busy), 512'(0));
            end
            if (e == 50) start = 1'b1;
            if (e == 51) start = 1'b0;
            @(negedge clk_in);
        end

        // degenerate frame
        exp_clear();
        sb.push_back(cur);
        cam_kernels_x = 16'd0;
        cam_lines_y   = 16'd5;
        start         = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check("deg_busy_c1", 512'(busy), 512'(1));
        check("deg_rdy_c1", 512'(analysis_rdy), 512'(0));
        @(negedge clk_in);
        check("deg_rdy_c2", 512'(analysis_rdy), 512'(1));
        check("deg_busy_c2", 512'(busy), 512'(0));
        repeat (3) @(negedge clk_in);

        check("sb_drained", 512'(sb.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spot_roi_tracker.md
# spot_roi_tracker

Parametrised spot finder for the camera pixel path. It reads one frame, word by word, from the spot-finder block RAM and tests one pixel per clock against a runtime threshold. Each bright pixel either opens a clamped rectangular region of interest (ROI) or adds a hit to the ROI that already contains it. It adds a start/busy/ready handshake, configurable memory latency, per-ROI hit counters and overflow reporting, and publishes results into a double-buffered output while the next frame is scanned.

## Interface
- PIX_W, 8, bits per pixel
- PIX_PER_WORD, 32, pixels per memory word (kernel)
- ADDR_W, 14, memory address width
- COORD_W, 10, width of each ROI coordinate
- NUM_ROIS_MAX, 10, ROI table depth (1..255)
- ROI_HALF_X, 3, ROI half-width in pixels
- ROI_HALF_Y, 3, ROI half-height in pixels
- MEM_LATENCY, 2, cycles from stable address to valid data_in (>=1)

Ports:
- clk_in  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin frame; sampled only in IDLE
- threshold  in  PIX_W  pixel is bright when value > threshold (strict)
- cam_kernels_x  in  16  words per line (K)
- cam_lines_y  in  16  lines per frame (L)
- mem_address  out  ADDR_W  word address to block RAM
- data_in  in  PIX_W*PIX_PER_WORD  word; pixel p = data_in[PIX_W*p +: PIX_W]
- busy  out  1  high from start accept through PUBLISH
- analysis_rdy  out  1  results valid; level
- num_rois  out  8  published ROI count
- roi_overflow  out  1  a spot was dropped because the table was full
- ROIs_output  out  NUM_ROIS_MAX*4*COORD_W  entry i at [4*COORD_W*i +: 4*COORD_W] = {x_start,y_start,x_end,y_end}
- roi_hits  out  NUM_ROIS_MAX*8  entry i hit count at [8*i +: 8]

## Operation
- States: IDLE, WAIT, SCAN, PUBLISH.
- IDLE: start=1 latches K, L, threshold and clears the working table, working count, overflow and counters. Sets mem_address=0, clears analysis_rdy, moves to WAIT. If K==0 or L==0, moves to PUBLISH instead.
- WAIT: holds for MEM_LATENCY cycles, then goes to SCAN with pixel index 0.
- SCAN: tests one pixel per cycle. pos_x = kernel*PIX_PER_WORD + p and pos_y = line, both at COORD_W bits. x_max = K*PIX_PER_WORD-1 and y_max = L-1, computed at start.
- Bright pixel, contained in a valid entry (inclusive bounds on all four coordinates): the lowest-index containing entry's hit count increments, saturating at 255.
- Bright pixel, not contained, count < NUM_ROIS_MAX: a new entry is written at index count. The entry is x_start=max(0,x-HX), y_start=max(0,y-HY), x_end=min(x_max,x+HX), y_end=min(y_max,y+HY), with hits=1, and count increments. The clamp comparisons do not underflow.
- Bright pixel, not contained, table full: the pixel is dropped and roi_overflow is set. Scanning continues, and hits on existing entries still count.
- An entry written in cycle n is visible to the containment test in cycle n+1.
- Last pixel of a word: mem_address increments. The kernel index wraps to 0 at K-1, and the line index then increments. If this was word K*L-1 the next state is PUBLISH, otherwise WAIT.
- PUBLISH (1 cycle): copies the working table to ROIs_output, roi_hits and num_rois, with unused entries zeroed. Sets analysis_rdy=1 and busy=0, then returns to IDLE.
- Published outputs hold until the next PUBLISH, including while the next frame is scanned. analysis_rdy clears on the next start accept.
- start is ignored while busy.

## Timing
- Reset (async assert): all outputs are 0, state is IDLE, and the working table is cleared. Release is synchronous to clk_in.
- Reset mid-frame aborts the frame. Published results are lost (zeroed).
- With start accepted at edge 0:
  - busy=1 and WAIT begin in cycle 1.
  - Each word takes MEM_LATENCY+PIX_PER_WORD cycles.
  - PUBLISH occurs in cycle 1+K*L*(MEM_LATENCY+PIX_PER_WORD).
  - analysis_rdy=1 in the following cycle.
- data_in must be stable for the whole SCAN of a word. mem_address is constant from WAIT entry to the last SCAN cycle.
- Degenerate frame (K or L = 0): PUBLISH in cycle 1, analysis_rdy=1 in cycle 2, num_rois=0.

## Test plan
- K=1, L=4, threshold=127; a single pixel of 200 at p=10, line 2 -> num_rois=1, entry0={7,0,13,3}, hits=1, roi_overflow=0.
- Same frame plus a pixel of 200 at p=11, line 2, and a pixel of 127 at p=30, line 0 -> num_rois=1, hits=2; the value 127 is not bright.
- Bright pixel at (0,0), K=1, L=2 -> entry0={0,0,3,1}. Bright pixel at p=31, line 1 -> entry={28,0,31,1}, showing the clamp at both edges.
- K=1, L=12, NUM_ROIS_MAX=10; one bright pixel at p=0 of every line with ROI_HALF_Y=0 -> num_rois=10, roi_overflow=1, entries 10 and 11 dropped.
- K=2, L=2, MEM_LATENCY=2, start at edge 0 -> mem_address steps 0,1,2,3 at 34-cycle intervals, PUBLISH in cycle 137, analysis_rdy rises in cycle 138. A start pulse during busy is ignored.
- reset_n pulsed low mid-SCAN -> all outputs 0 immediately. A subsequent start rescans a frame correctly from address 0.
